// File: rtl/gcd_unit.sv
// gcd_unit: subtractive-Euclid GCD engine with IDLE/CALC/DONE handshake
// Ports: clk, rst_n (async, active-low); start + a_in/b_in sampled only while ready;
// ready/busy/done flag IDLE/CALC/DONE; gcd_out and iter_count hold the last result
// (iter_count = subtractions performed, saturating at all-ones).
module gcd_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iter_count
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, cnt, cnt_next;
  logic gt, eq, fin;
  assign gt = a > b;
  assign eq = a == b;
  // A zero operand or equal operands both finish; A|B covers every such case.
  assign fin = eq || a == '0 || b == '0;
  assign cnt_next = &cnt ? cnt : cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      gcd_out    <= '0;
      iter_count <= '0;
      a          <= '0;
      b          <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          ready <= 1'b0;
          busy  <= 1'b1;
          a     <= a_in;
          b     <= b_in;
          cnt   <= '0;
        end
        CALC: if (fin) begin
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          gcd_out    <= a | b;
          iter_count <= cnt;
        end else begin
          a   <= gt ? a - b : a;
          b   <= gt ? b : b - a;
          cnt <= cnt_next;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed and random checks of gcd_unit at WIDTH=16 and WIDTH=8
module tb_gcd_unit;
  logic clk = 0;
  logic rst_n = 0;
  logic s16 = 0, s8 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic r16, y16, d16, r8, y8, d8;
  logic [15:0] g16, c16;
  logic [7:0] g8, c8;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  gcd_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a_in(a16), .b_in(b16),
    .ready(r16), .busy(y16), .done(d16), .gcd_out(g16), .iter_count(c16));
  gcd_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a_in(a8), .b_in(b8),
    .ready(r8), .busy(y8), .done(d8), .gcd_out(g8), .iter_count(c8));

  always @(negedge clk) begin
    checks++;
    if (!$onehot({r16, y16, d16}) || !$onehot({r8, y8, d8})) begin
      errors++;
      $display("FAIL onehot: w16 r/b/d=%b%b%b w8 r/b/d=%b%b%b, need exactly one high",
               r16, y16, d16, r8, y8, d8);
    end
  end

  // Reference: subtractive GCD with saturating step count.
  function automatic void model(input int w, input longint a, input longint b,
                                output longint g, output longint n);
    longint mx = (64'd1 << w) - 1;
    n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) a = a - b; else b = b - a;
      if (n != mx) n++;
    end
    g = a | b;
  endfunction

  task automatic run16(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    a16 = a; b16 = b; s16 = 1;
    @(negedge clk);
    s16 = 0; a16 = $urandom; b16 = $urandom;
    lat = 0;
    while (!d16 && lat < 70000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; s8 = 1;
    @(negedge clk);
    s8 = 0; a8 = $urandom; b8 = $urandom;
    lat = 0;
    while (!d8 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({r16, y16, d16, g16, c16} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: r/b/d=%b%b%b gcd=%h cnt=%h, need 100 0 0", r16, y16, d16, g16, c16);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic;
    int lat;
    run16(16'd12, 16'd18, lat);
    checks++;
    if (lat !== 3 || g16 !== 16'd6 || c16 !== 16'd2) begin
      errors++;
      $display("FAIL gcd_12_18: lat=%0d gcd=%0d cnt=%0d, need 3 6 2", lat, g16, c16);
    end
    @(negedge clk);
    checks++;
    if (d16 !== 1'b0 || r16 !== 1'b1 || g16 !== 16'd6) begin
      errors++;
      $display("FAIL done_pulse: done=%b ready=%b gcd=%0d, need 0 1 6", d16, r16, g16);
    end
    run16(16'd17, 16'd5, lat);
    checks++;
    if (lat !== 7 || g16 !== 16'd1 || c16 !== 16'd6) begin
      errors++;
      $display("FAIL gcd_17_5: lat=%0d gcd=%0d cnt=%0d, need 7 1 6", lat, g16, c16);
    end
  endtask

  task automatic test_zero;
    int lat;
    run16(16'd0, 16'd9, lat);
    checks++;
    if (lat !== 1 || g16 !== 16'd9 || c16 !== 16'd0) begin
      errors++;
      $display("FAIL gcd_0_9: lat=%0d gcd=%0d cnt=%0d, need 1 9 0", lat, g16, c16);
    end
    run16(16'd0, 16'd0, lat);
    checks++;
    if (lat !== 1 || g16 !== 16'd0 || c16 !== 16'd0) begin
      errors++;
      $display("FAIL gcd_0_0: lat=%0d gcd=%0d cnt=%0d, need 1 0 0", lat, g16, c16);
    end
    run16(16'd7, 16'd7, lat);
    checks++;
    if (lat !== 1 || g16 !== 16'd7 || c16 !== 16'd0) begin
      errors++;
      $display("FAIL gcd_7_7: lat=%0d gcd=%0d cnt=%0d, need 1 7 0", lat, g16, c16);
    end
  endtask

  task automatic test_worst;
    int lat;
    run16(16'hFFFF, 16'd1, lat);
    checks++;
    if (lat !== 65535 || g16 !== 16'd1 || c16 !== 16'hFFFE) begin
      errors++;
      $display("FAIL gcd_ffff_1: lat=%0d gcd=%0d cnt=%h, need 65535 1 fffe", lat, g16, c16);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    a16 = 16'd12; b16 = 16'd18; s16 = 1;
    @(negedge clk);
    a16 = 16'd5; b16 = 16'd5;
    @(negedge clk);
    s16 = 0;
    lat = 1;
    while (!d16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3 || g16 !== 16'd6 || c16 !== 16'd2) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d gcd=%0d cnt=%0d, need 3 6 2", lat, g16, c16);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (r16 !== 1'b1 || g16 !== 16'd6) begin
      errors++;
      $display("FAIL no_restart: ready=%b gcd=%0d, need 1 6", r16, g16);
    end
  endtask

  task automatic test_reset_calc;
    bit seen = 0;
    @(negedge clk);
    a16 = 16'd1000; b16 = 16'd3; s16 = 1;
    @(negedge clk);
    s16 = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({r16, y16, d16, g16, c16} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL reset_in_calc: r/b/d=%b%b%b gcd=%h cnt=%h, need 100 0 0", r16, y16, d16, g16, c16);
    end
    repeat (3) @(negedge clk) seen |= d16;
    rst_n = 1;
    repeat (5) @(negedge clk) seen |= d16 | y16;
    checks++;
    if (seen !== 1'b0 || r16 !== 1'b1 || g16 !== 16'd0) begin
      errors++;
      $display("FAIL abort_no_done: seen=%b ready=%b gcd=%0d, need 0 1 0", seen, r16, g16);
    end
  endtask

  task automatic test_width8;
    int lat;
    run8(8'd255, 8'd15, lat);
    checks++;
    if (lat !== 17 || g8 !== 8'd15 || c8 !== 8'd16) begin
      errors++;
      $display("FAIL w8_255_15: lat=%0d gcd=%0d cnt=%0d, need 17 15 16", lat, g8, c8);
    end
    run8(8'd255, 8'd1, lat);
    checks++;
    if (lat !== 255 || g8 !== 8'd1 || c8 !== 8'd254) begin
      errors++;
      $display("FAIL w8_255_1: lat=%0d gcd=%0d cnt=%0d, need 255 1 254", lat, g8, c8);
    end
  endtask

  task automatic test_random;
    int lat, k;
    longint g, n;
    logic [7:0] a, b;
    k = 0;
    while (k < 1000) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      model(8, longint'(a), longint'(b), g, n);
      if (n <= 32) begin
        run8(a, b, lat);
        checks++;
        if (lat !== int'(n) + 1 || g8 !== 8'(g) || c8 !== 8'(n)) begin
          errors++;
          $display("FAIL rand %0d,%0d: lat=%0d gcd=%0d cnt=%0d, need %0d %0d %0d",
                   a, b, lat, g8, c8, n + 1, g, n);
        end
        k++;
      end
    end
  endtask

  initial begin
    #12;
    test_reset;
    test_basic;
    test_zero;
    test_ignore_start;
    test_reset_calc;
    test_width8;
    test_random;
    test_worst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_unit.md
GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 Parameter: WIDTH, default 16, operand, result and iteration-counter width; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request; sampled only while ready=1.
REQ-005 Port: a_in  input  WIDTH  operand A, unsigned; sampled on the accepting edge only.
REQ-006 Port: b_in  input  WIDTH  operand B, unsigned; sampled on the accepting edge only.
REQ-007 Port: ready  output  1  high in IDLE only.
REQ-008 Port: busy  output  1  high in CALC only.
REQ-009 Port: done  output  1  one-cycle pulse, high in DONE only.
REQ-010 Port: gcd_out  output  WIDTH  result; valid from done high until the next accepted start.
REQ-011 Port: iter_count  output  WIDTH  subtractions performed for the last result; saturates at all-ones.

Function
REQ-012 The block SHALL implement a state machine with exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE: on a clock edge with start=1, capture a_in into A and b_in into B, clear the iteration counter, and go to CALC; otherwise stay in IDLE.
REQ-014 start SHALL be ignored in CALC and DONE; no queuing, no restart.
REQ-015 CALC, one decision per cycle, in priority order:
- A==0 or B==0: result = A|B; go to DONE.
- A==B: result = A; go to DONE.
- A>B: A <= A-B; stay in CALC.
- A<B: B <= B-A; stay in CALC.
REQ-016 Subtraction SHALL be WIDTH-bit unsigned; it never underflows because the larger operand is always the minuend.
REQ-017 The comparison SHALL be a single unsigned WIDTH-bit compare producing lt/gt/eq on the current A and B registers.
REQ-018 The iteration counter SHALL increment once per subtraction cycle and hold at all-ones once it reaches all-ones.
REQ-019 On the CALC to DONE edge, gcd_out and iter_count SHALL load the result and the counter value.
REQ-020 DONE SHALL last exactly one cycle, then go unconditionally to IDLE.
REQ-021 gcd_out and iter_count SHALL hold their values through IDLE until the next CALC to DONE transition.
REQ-022 Latency: if S is the start-accepting edge and N is the subtraction count, done is high in the cycle following edge S+N+1.
REQ-023 Worst-case N SHALL be 2^WIDTH-2, for operands (2^WIDTH-1, 1); no timeout is provided.
REQ-024 Inputs a_in and b_in SHALL NOT affect any state except on the accepting edge.

Reset
REQ-025 While rst_n=0, the following SHALL apply immediately, independent of clk: state=IDLE; ready=1; busy=0; done=0; gcd_out=0; iter_count=0; A=0; B=0.
REQ-026 Reset asserted in CALC or DONE SHALL abort the operation with no done pulse; gcd_out and iter_count read 0.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first clock edge that sees start=1.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- a=12, b=18 -> gcd_out=6, iter_count=2, done high after edge S+3, single-cycle pulse, then ready=1.
- a=17, b=5 -> gcd_out=1, iter_count=6.
- a=0, b=9 -> gcd_out=9, iter_count=0, done after edge S+1.
- a=0, b=0 -> gcd_out=0, iter_count=0.
- a=0xFFFF, b=1 (WIDTH=16) -> gcd_out=1, iter_count=0xFFFE.
- Accept a=12, b=18, then pulse start with a=5, b=5 on edge S+1 -> ignored, gcd_out=6.
- Assert rst_n=0 during CALC -> outputs read reset values immediately, no done pulse.
- Re-run with WIDTH=8: a=255, b=15 -> gcd_out=15, iter_count=16.
REQ-029 The bench SHALL check every result against a reference GCD model, using at least 1000 random operand pairs at WIDTH=8.
REQ-030 The bench SHALL assert continuously that ready, busy and done are mutually exclusive and exactly one of them is high.
